// File: rtl/gsh_brinfo_queue_if.sv
// Branch-info queue bundle: fetch allocation, execute resolution and gshare update/repair signals.
// alloc: a transfer happens on a cycle where i_alloc_valid & o_alloc_ready are both high; o_alloc_tag is meaningful only then.
interface gsh_brinfo_queue_if #(
    parameter int IDX_W = 10,
    parameter int TAG_W = 3
);
    logic             i_alloc_valid;
    logic             o_alloc_ready;
    logic [IDX_W-1:0] i_alloc_idx;
    logic [IDX_W-1:0] i_alloc_ghr;
    logic             i_alloc_pred;
    logic [TAG_W-1:0] o_alloc_tag;
    logic             i_resolve_valid;
    logic [TAG_W-1:0] i_resolve_tag;
    logic             i_resolve_taken;
    logic             o_pht_wr_en;
    logic [IDX_W-1:0] o_pht_wr_addr;
    logic             o_jmpcond;
    logic             o_ghr_restore_en;
    logic [IDX_W-1:0] o_ghr_restore;

    modport slave (
        input  i_alloc_valid, i_alloc_idx, i_alloc_ghr, i_alloc_pred,
        input  i_resolve_valid, i_resolve_tag, i_resolve_taken,
        output o_alloc_ready, o_alloc_tag,
        output o_pht_wr_en, o_pht_wr_addr, o_jmpcond, o_ghr_restore_en, o_ghr_restore
    );

    modport master (
        output i_alloc_valid, i_alloc_idx, i_alloc_ghr, i_alloc_pred,
        output i_resolve_valid, i_resolve_tag, i_resolve_taken,
        input  o_alloc_ready, o_alloc_tag,
        input  o_pht_wr_en, o_pht_wr_addr, o_jmpcond, o_ghr_restore_en, o_ghr_restore
    );
endinterface

// File: rtl/gsh_brinfo_queue.sv
// In-order retire queue for gshare branches: records prediction state at fetch, takes out-of-order
// resolutions, emits one PHT update per retired branch and a GHR repair on mispredict.
module gsh_brinfo_queue #(
    parameter int IDX_W = 10,
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    gsh_brinfo_queue_if.slave bq,
    output logic [TAG_W:0]    o_count
);
    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d, resolved_q, resolved_d;

    logic [IDX_W-1:0] idx_mem [DEPTH];
    logic [IDX_W-2:0] ghr_mem [DEPTH];
    logic [DEPTH-1:0] pred_mem, taken_mem;

    logic             pht_wr_en_q, pht_wr_en_d;
    logic [IDX_W-1:0] pht_wr_addr_q, pht_wr_addr_d;
    logic             jmpcond_q, jmpcond_d;
    logic             ghr_restore_en_q, ghr_restore_en_d;
    logic [IDX_W-1:0] ghr_restore_q, ghr_restore_d;

    logic             full, res_ok, mispredict_now, alloc_fire, retire;
    logic [TAG_W-1:0] tag_age;

    assign full           = (count_q == (TAG_W+1)'(DEPTH));
    assign res_ok         = bq.i_resolve_valid & valid_q[bq.i_resolve_tag] & ~resolved_q[bq.i_resolve_tag];
    assign mispredict_now = res_ok & (bq.i_resolve_taken != pred_mem[bq.i_resolve_tag]);
    assign bq.o_alloc_ready = ~full & ~i_flush & ~mispredict_now;
    assign alloc_fire     = bq.i_alloc_valid & bq.o_alloc_ready;
    // Retire decision uses start-of-cycle state, so a same-cycle resolve of the head waits one cycle.
    assign retire         = valid_q[head_q] & resolved_q[head_q] & ~i_flush;
    assign tag_age        = bq.i_resolve_tag - head_q;

    always_comb begin
        logic [TAG_W-1:0] age_i;
        age_i            = '0;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        valid_d          = valid_q;
        resolved_d       = resolved_q;
        pht_wr_en_d      = 1'b0;
        pht_wr_addr_d    = pht_wr_addr_q;
        jmpcond_d        = jmpcond_q;
        ghr_restore_en_d = 1'b0;
        ghr_restore_d    = ghr_restore_q;
        if (i_flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            valid_d    = '0;
            resolved_d = '0;
        end else begin
            if (retire) begin
                pht_wr_en_d        = 1'b1;
                pht_wr_addr_d      = idx_mem[head_q];
                jmpcond_d          = taken_mem[head_q];
                valid_d[head_q]    = 1'b0;
                resolved_d[head_q] = 1'b0;
                head_d             = head_q + 1'b1;
            end
            if (res_ok) begin
                resolved_d[bq.i_resolve_tag] = 1'b1;
            end
            if (mispredict_now) begin
                ghr_restore_en_d = 1'b1;
                ghr_restore_d    = {ghr_mem[bq.i_resolve_tag], bq.i_resolve_taken};
                // Squash everything younger than the mispredicted branch (age measured from head).
                for (int i = 0; i < DEPTH; i++) begin
                    age_i = TAG_W'(i) - head_q;
                    if (age_i > tag_age) begin
                        valid_d[i]    = 1'b0;
                        resolved_d[i] = 1'b0;
                    end
                end
                tail_d  = bq.i_resolve_tag + 1'b1;
                count_d = {1'b0, tag_age} + (TAG_W+1)'(1) - {{TAG_W{1'b0}}, retire};
            end else begin
                if (alloc_fire) begin
                    valid_d[tail_q]    = 1'b1;
                    resolved_d[tail_q] = 1'b0;
                    tail_d             = tail_q + 1'b1;
                end
                count_d = count_q + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, retire};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            valid_q          <= '0;
            resolved_q       <= '0;
            pht_wr_en_q      <= 1'b0;
            pht_wr_addr_q    <= '0;
            jmpcond_q        <= 1'b0;
            ghr_restore_en_q <= 1'b0;
            ghr_restore_q    <= '0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            valid_q          <= valid_d;
            resolved_q       <= resolved_d;
            pht_wr_en_q      <= pht_wr_en_d;
            pht_wr_addr_q    <= pht_wr_addr_d;
            jmpcond_q        <= jmpcond_d;
            ghr_restore_en_q <= ghr_restore_en_d;
            ghr_restore_q    <= ghr_restore_d;
        end
    end

    // Payload is qualified by valid/resolved bits, so it carries no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            idx_mem[tail_q]  <= bq.i_alloc_idx;
            ghr_mem[tail_q]  <= bq.i_alloc_ghr[IDX_W-2:0];
            pred_mem[tail_q] <= bq.i_alloc_pred;
        end
        if (res_ok && !i_flush) begin
            taken_mem[bq.i_resolve_tag] <= bq.i_resolve_taken;
        end
    end

    assign bq.o_alloc_tag      = tail_q;
    assign bq.o_pht_wr_en      = pht_wr_en_q;
    assign bq.o_pht_wr_addr    = pht_wr_addr_q;
    assign bq.o_jmpcond        = jmpcond_q;
    assign bq.o_ghr_restore_en = ghr_restore_en_q;
    assign bq.o_ghr_restore    = ghr_restore_q;
    assign o_count             = count_q;
endmodule
